// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator
//   Parallel-to-serial transmitter for the bit-stream pattern path. A pattern
//   word is accepted through a valid/ready handshake and shifted out MSB first,
//   one bit per clock. With repeat_en held high the pattern restarts with no gap.
//
// Ports
//   clock      : single clock, all state updates on the rising edge
//   reset      : synchronous, active-high
//   load_valid : load request, accepted when load_ready is high
//   load_ready : high only while idle
//   load_data  : pattern word; bits [len-1:0] are sent, bit len-1 first
//   load_len   : number of bits to send (values above WIDTH clamp to WIDTH)
//   repeat_en  : sampled on the last-bit cycle; 1 restarts the pattern
//   abort      : synchronous stop back to idle, no done pulse
//   o          : serial data, 0 whenever o_valid is low
//   o_valid    : high while o carries a pattern bit
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse after the last bit of a non-repeating pass
//
// State table
//   IDLE  | waiting for a load; load_ready=1
//   SHIFT | driving pattern bits on o, idx points at the bit on the line
//   DONE  | single-cycle completion pulse
module serial_pattern_generator #(
    parameter int WIDTH = 10,
    localparam int LW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    input  logic             repeat_en,
    input  logic             abort,
    output logic             o,
    output logic             o_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    idx;

    logic [LW-1:0]    len_c;
    logic [LW-1:0]    len_c_m1;
    logic [LW-1:0]    len_q_m1;
    logic [LW-1:0]    idx_m1;

    always_comb begin
        len_c = load_len;
        if (load_len > LW'(WIDTH)) begin
            len_c = LW'(WIDTH);
        end
        len_c_m1 = len_c - LW'(1);
        len_q_m1 = len_q - LW'(1);
        idx_m1   = idx - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            data_q     <= '0;
            len_q      <= '0;
            idx        <= '0;
            o          <= 1'b0;
            o_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // abort outranks a simultaneous load request
                    if (load_valid && !abort) begin
                        data_q     <= load_data;
                        len_q      <= len_c;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        if (len_c != '0) begin
                            state   <= SHIFT;
                            idx     <= len_c_m1;
                            o       <= load_data[len_c_m1];
                            o_valid <= 1'b1;
                        end else begin
                            // empty pattern: nothing to shift, just report completion
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state      <= IDLE;
                        o          <= 1'b0;
                        o_valid    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
                    end else if (idx == '0) begin
                        if (repeat_en) begin
                            // wrap straight to the first bit so o_valid has no bubble
                            idx <= len_q_m1;
                            o   <= data_q[len_q_m1];
                        end else begin
                            state   <= DONE;
                            o       <= 1'b0;
                            o_valid <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        idx <= idx_m1;
                        o   <= data_q[idx_m1];
                    end
                end

                DONE: begin
                    // leaves after one cycle whether or not abort is asserted
                    state      <= IDLE;
                    o          <= 1'b0;
                    o_valid    <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    o          <= 1'b0;
                    o_valid    <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator: hand-computed bit sequences for
// single passes, repeat mode, abort, zero/over-range lengths and ignored loads.
module tb_serial_pattern_generator;

    localparam int WIDTH = 10;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    load_len;
    logic             repeat_en;
    logic             abort;
    logic             o;
    logic             o_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    serial_pattern_generator #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .repeat_en  (repeat_en),
        .abort      (abort),
        .o          (o),
        .o_valid    (o_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " o"}, o, 0);
        check({tag, " o_valid"}, o_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " load_ready"}, load_ready, 1);
    endtask

    // issue a one-cycle load; returns after edge E0 (now in cycle E0+1)
    task automatic do_load(input logic [WIDTH-1:0] d, input logic [LW-1:0] len);
        load_data  = d;
        load_len   = len;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    // expects `len` bits from pattern `pat` MSB (bit len-1) first, then the done pulse
    task automatic expect_pass(input string tag, input logic [WIDTH-1:0] pat, input int len);
        logic [WIDTH-1:0] p;
        p = pat;
        for (int i = len - 1; i >= 0; i--) begin
            check({tag, " bit"}, o, p[i]);
            check({tag, " o_valid"}, o_valid, 1);
            check({tag, " busy"}, busy, 1);
            check({tag, " done low"}, done, 0);
            check({tag, " load_ready low"}, load_ready, 0);
            step();
        end
        check({tag, " done pulse"}, done, 1);
        check({tag, " o_valid after"}, o_valid, 0);
        check({tag, " o after"}, o, 0);
        check({tag, " busy in done"}, busy, 1);
        check({tag, " load_ready in done"}, load_ready, 0);
        step();
        check_idle({tag, " back idle"});
    endtask

    initial begin
        logic [2:0] rep_pat;
        rep_pat = 3'b001;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        repeat_en  = 1'b0;
        abort      = 1'b0;

        // 1. reset
        step();
        step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("post reset");

        // 1b. reset mid-shift
        do_load(10'b1111111111, 4'd10);
        step();
        check("pre-reset o_valid", o_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("mid-shift reset");

        // 2. full-width pattern, no repeat
        do_load(10'b1110011001, 4'd10);
        expect_pass("pat10", 10'b1110011001, 10);

        // 3. repeat mode: 0,0,1 continuously, then release repeat_en mid-pass
        repeat_en = 1'b1;
        do_load(10'b0000000001, 4'd3);
        for (int i = 0; i < 9; i++) begin
            check("rep bit", o, rep_pat[2 - (i % 3)]);
            check("rep o_valid", o_valid, 1);
            check("rep done low", done, 0);
            step();
        end
        check("rep pass4 first bit", o, 0);
        step();
        repeat_en = 1'b0;
        check("rep pass4 second bit", o, 0);
        check("rep pass4 o_valid", o_valid, 1);
        step();
        check("rep pass4 last bit", o, 1);
        check("rep pass4 last o_valid", o_valid, 1);
        step();
        check("rep done pulse", done, 1);
        check("rep o_valid end", o_valid, 0);
        step();
        check("rep done single", done, 0);
        check_idle("rep idle");

        // 4. abort during the 4th bit
        do_load(10'b1010101010, 4'd10);
        step();
        step();
        step();
        check("abort 4th bit", o, 0);
        check("abort 4th o_valid", o_valid, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
            check("abort no done", done, 0);
            step();
        end

        // 4b. abort in IDLE beats load_valid
        abort = 1'b1;
        do_load(10'b1111111111, 4'd5);
        abort = 1'b0;
        check_idle("idle abort");

        // 5. zero length: straight to DONE
        do_load(10'b1111111111, 4'd0);
        check("len0 done", done, 1);
        check("len0 o_valid", o_valid, 0);
        check("len0 busy", busy, 1);
        check("len0 load_ready", load_ready, 0);
        step();
        check_idle("len0 idle");

        // 5b. over-range length clamps to WIDTH
        do_load(10'b1011001110, 4'd15);
        expect_pass("len15", 10'b1011001110, 10);

        // 5c. short pattern uses only the low bits
        do_load(10'b1111110110, 4'd4);
        expect_pass("len4", 10'b0000000110, 4);

        // 6. load during SHIFT is ignored
        do_load(10'b1100101011, 4'd10);
        load_data  = 10'b0011010100;
        load_len   = 4'd5;
        load_valid = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            logic [WIDTH-1:0] pa;
            pa = 10'b1100101011;
            check("ignore bit", o, pa[i]);
            check("ignore o_valid", o_valid, 1);
            check("ignore load_ready", load_ready, 0);
            if (i == 7) load_valid = 1'b0;
            step();
        end
        check("ignore done", done, 1);
        step();
        check_idle("ignore idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
